led_snake_engine: RTL and testbench
===================================

Name: led_snake_engine

Overview:
- Parametrised LED snake generator that replaces the fixed program-choice counter, frame prescaler and frame counter with one block.
- Holds LED_NUM LEDs, a configurable snake length, five display programs selected by a button, programmable frame speed, and pause.
- Drives the LED bar directly.
- Exports the selected program number for the existing 3-bit-to-7-segment transcoder.

Parameters:
- LED_NUM, 8, number of LEDs. Legal range 2..32.
- SNAKE_LEN, 3, lit segment length for programs 0-2. Legal range 1..LED_NUM-1.
- FRAME_CYCLES, 2500000, clk cycles per base frame. Minimum 2.
- NUM_PROGRAMS, 5, number of selectable programs. Fixed set 0..4; must be ≤8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_program  in  1  debounced, asynchronous-to-clk button level; each rising edge advances the program.
- speed  in  3  frame period multiplier; period = FRAME_CYCLES*(speed+1).
- pause  in  1  high freezes the prescaler and pattern.
- leds  out  LED_NUM  registered LED drive, bit 0 = first LED.
- program_choosen  out  3  current program, 0..NUM_PROGRAMS-1.
- frame_tick  out  1  one-cycle pulse per frame step.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous assert, active-low; every register clears on rst_n low regardless of clk.
- Reset values: program_choosen=0, frame_tick=0, leds = low SNAKE_LEN bits set (8/3 → 0x07). Internal state: t=0, dir=up, s=0, phase=0, prescaler=0, divider=0, button sync/edge regs=0.
- Button path:
  - 2-FF synchroniser, then a registered previous value; edge = sync2 & ~prev.
  - program_choosen updates on the 3rd rising clk edge after btn_program is first sampled high.
  - Held level counts once.
  - Increments wrap NUM_PROGRAMS-1 → 0.
- Program change on an edge cycle:
  - Pattern state restarts: t=0, dir=up, s=0, phase=0.
  - prescaler=0, divider=0.
  - frame_tick is suppressed that cycle even if terminal count coincides.
- Prescaler:
  - Base counter runs 0..FRAME_CYCLES-1; at terminal it wraps to 0 and asserts base_tick.
  - Divider counts base_ticks. frame_tick is registered high for one cycle when base_tick and divider>=speed; the divider then clears.
  - ">=" makes a speed decrease take effect without a long stall.
  - speed is sampled live.
- Pause: while pause=1, base counter, divider and pattern state hold, frame_tick=0 and leds hold. Counting resumes from the held values.
- Pattern state advances on the cycle frame_tick is registered. leds is a registered decode of the state, so it changes one clk after frame_tick rises. On program change, leds shows the new start pattern one clk after program_choosen updates.
- Program 0, run up:
  - Lit bits are (t+i) mod LED_NUM for i=0..SNAKE_LEN-1.
  - Each frame t=(t+1) mod LED_NUM, so 7→0 for LED_NUM=8.
- Program 1, run down: same decode as program 0; each frame t=(t-1) mod LED_NUM, so 0→LED_NUM-1.
- Program 2, bounce:
  - Same decode, no wrap; t ranges 0..LED_NUM-SNAKE_LEN.
  - dir=up: t+1. On reaching LED_NUM-SNAKE_LEN, dir flips to down for the next frame.
  - dir=down: t-1. On reaching 0, dir flips to up.
  - End positions are shown for exactly one frame.
- Program 3, fill/drain:
  - s runs 0..2*LED_NUM-1 and wraps to 0.
  - For s<=LED_NUM, leds = low s bits set; otherwise low (2*LED_NUM-s) bits set.
- Program 4, blink: phase toggles each frame; leds = all phase (reset/start = all off).
- Reset mid-operation: outputs return to reset values asynchronously. After release, the first frame_tick occurs FRAME_CYCLES*(speed+1) cycles later.

Test Plan:
- Program 0, LED_NUM=8, SNAKE_LEN=3, FRAME_CYCLES=4, speed=0:
  - After reset, leds=0x07, and frame_tick pulses every 4 cycles.
  - leds steps 0x0E, 0x1C, 0x38, 0x70, 0xE0, 0xC1, 0x83, 0x07.
- Program 1: one button press → program_choosen=1, leds=0x07; successive frames → 0x83, 0xC1, 0xE0.
- Program 2, bounce:
  - leds steps 0x07→0x0E→0x1C→0x38→0x70→0xE0→0x70→0x38.
  - 0xE0 appears for exactly one frame.
- Program 3, fill/drain:
  - Sequence 0x00, 0x01, 0x03 … 0xFF, 0x7F … 0x01, 0x00 (16-frame period).
- Program 4, button and timing:
  - Program 4 alternates 0x00/0xFF.
  - Fifth press wraps to 0, leds=0x07.
  - Button held 100 cycles → exactly one increment.
  - Press coincident with terminal count → no frame_tick, prescaler restarted.
- Speed, pause and reset:
  - speed=2 → ticks every 12 cycles; switching to speed=0 mid-count gives a tick within ≤4 cycles.
  - pause held 20 cycles → no ticks and leds frozen; after release the next tick arrives after the remaining count.
  - rst_n low mid-frame → immediate reset values.

Source files
------------

// File: rtl/led_snake_engine.sv
// LED snake generator: button-selected display program, frame prescaler with speed
// multiplier and pause, registered LED bar drive.
module led_snake_engine #(
  parameter int unsigned LED_NUM      = 8,
  parameter int unsigned SNAKE_LEN    = 3,
  parameter int unsigned FRAME_CYCLES = 2500000,
  parameter int unsigned NUM_PROGRAMS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_program,
  input  logic [2:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] leds,
  output logic [2:0]         program_choosen,
  output logic               frame_tick
);

  localparam int unsigned TW = $clog2(LED_NUM);
  localparam int unsigned SW = $clog2(2 * LED_NUM);
  localparam int unsigned BW = $clog2(FRAME_CYCLES);

  localparam logic [TW-1:0]      TMax      = TW'(LED_NUM - 1);
  localparam logic [TW-1:0]      BounceMax = TW'(LED_NUM - SNAKE_LEN);
  localparam logic [TW:0]        TLen      = (TW + 1)'(LED_NUM);
  localparam logic [SW-1:0]      SMax      = SW'(2 * LED_NUM - 1);
  localparam logic [SW-1:0]      SHalf     = SW'(LED_NUM);
  localparam logic [SW:0]        SFull     = (SW + 1)'(2 * LED_NUM);
  localparam logic [BW-1:0]      BaseMax   = BW'(FRAME_CYCLES - 1);
  localparam logic [2:0]         ProgLast  = 3'(NUM_PROGRAMS - 1);
  localparam logic [LED_NUM-1:0] SnakeMask = LED_NUM'((64'd1 << SNAKE_LEN) - 64'd1);

  logic               btn_sync1_q, btn_sync2_q, btn_prev_q;
  logic [2:0]         prog_q, prog_d;
  logic [BW-1:0]      base_q, base_d;
  logic [2:0]         div_q, div_d;
  logic               tick_q, tick_d;
  logic [TW-1:0]      t_q, t_d;
  logic               dir_q, dir_d;  // 1 = moving down
  logic [SW-1:0]      s_q, s_d;
  logic               phase_q, phase_d;
  logic [LED_NUM-1:0] leds_q, leds_d;
  logic               btn_edge;
  logic [TW:0]        rot_amt;
  logic [SW:0]        fill_n;

  assign btn_edge = btn_sync2_q & ~btn_prev_q;

  always_comb begin
    prog_d  = prog_q;
    base_d  = base_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    t_d     = t_q;
    dir_d   = dir_q;
    s_d     = s_q;
    phase_d = phase_q;
    if (btn_edge) begin
      // Program change restarts everything and swallows a coincident frame tick.
      prog_d  = (prog_q == ProgLast) ? 3'd0 : prog_q + 3'd1;
      base_d  = '0;
      div_d   = '0;
      t_d     = '0;
      dir_d   = 1'b0;
      s_d     = '0;
      phase_d = 1'b0;
    end else if (!pause) begin
      if (base_q == BaseMax) begin
        base_d = '0;
        if (div_q >= speed) begin
          div_d  = '0;
          tick_d = 1'b1;
        end else begin
          div_d = div_q + 3'd1;
        end
      end else begin
        base_d = base_q + BW'(1);
      end
      if (tick_d) begin
        case (prog_q)
          3'd0: t_d = (t_q == TMax) ? '0 : t_q + TW'(1);
          3'd1: t_d = (t_q == '0) ? TMax : t_q - TW'(1);
          3'd2: begin
            if (!dir_q) begin
              t_d = t_q + TW'(1);
              if (t_d == BounceMax) dir_d = 1'b1;
            end else begin
              t_d = t_q - TW'(1);
              if (t_d == '0) dir_d = 1'b0;
            end
          end
          3'd3: s_d = (s_q == SMax) ? '0 : s_q + SW'(1);
          3'd4: phase_d = ~phase_q;
          default: ;
        endcase
      end
    end
  end

  // Rotation by t; shifting by LED_NUM yields zero so t = 0 needs no special case.
  assign rot_amt = TLen - {1'b0, t_q};
  assign fill_n  = (s_q <= SHalf) ? {1'b0, s_q} : SFull - {1'b0, s_q};

  always_comb begin
    leds_d = '0;
    case (prog_q)
      3'd0, 3'd1, 3'd2: leds_d = (SnakeMask << t_q) | (SnakeMask >> rot_amt);
      3'd3:             leds_d = ~({LED_NUM{1'b1}} << fill_n);
      3'd4:             leds_d = {LED_NUM{phase_q}};
      default:          leds_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      btn_prev_q  <= 1'b0;
      prog_q      <= '0;
      base_q      <= '0;
      div_q       <= '0;
      tick_q      <= 1'b0;
      t_q         <= '0;
      dir_q       <= 1'b0;
      s_q         <= '0;
      phase_q     <= 1'b0;
      leds_q      <= SnakeMask;
    end else begin
      btn_sync1_q <= btn_program;
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_sync2_q;
      prog_q      <= prog_d;
      base_q      <= base_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      t_q         <= t_d;
      dir_q       <= dir_d;
      s_q         <= s_d;
      phase_q     <= phase_d;
      leds_q      <= leds_d;
    end
  end

  assign leds            = leds_q;
  assign program_choosen = prog_q;
  assign frame_tick      = tick_q;

endmodule

// File: tb/tb_led_snake_engine.sv
// Directed bench for led_snake_engine with LED_NUM=8, SNAKE_LEN=3, FRAME_CYCLES=4.
module tb_led_snake_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_program = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       pause = 1'b0;
  logic [7:0] leds;
  logic [2:0] program_choosen;
  logic       frame_tick;

  int n_cmp = 0;
  int n_fail = 0;

  led_snake_engine #(
    .LED_NUM(8),
    .SNAKE_LEN(3),
    .FRAME_CYCLES(4),
    .NUM_PROGRAMS(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_program(btn_program),
    .speed(speed),
    .pause(pause),
    .leds(leds),
    .program_choosen(program_choosen),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Negedges until frame_tick is seen high; 0 when the bound expires.
  task automatic count_to_tick(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic next_frame(output logic [7:0] l, output int cyc);
    count_to_tick(cyc);
    @(negedge clk);
    l = leds;
  endtask

  task automatic press();
    btn_program = 1'b1;
    repeat (3) @(negedge clk);
    btn_program = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (leds !== 8'h07) begin n_fail++; $display("FAIL reset_leds got %h want 07", leds); end
    n_cmp++; if (program_choosen !== 3'd0) begin n_fail++; $display("FAIL reset_prog got %0d want 0", program_choosen); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    rst_n = 1'b1;
    count_to_tick(cyc);
    n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL first_tick got %0d want 4", cyc); end
  endtask

  task automatic test_prog0();
    logic [7:0] exp [8];
    logic [7:0] l;
    int cyc;
    exp = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};
    @(negedge clk);
    n_cmp++; if (leds !== exp[0]) begin n_fail++; $display("FAIL prog0_f0 got %h want %h", leds, exp[0]); end
    for (int i = 1; i < 8; i++) begin
      next_frame(l, cyc);
      n_cmp++; if (l !== exp[i] || cyc != 3) begin
        n_fail++; $display("FAIL prog0_f%0d got %h/%0d want %h/3", i, l, cyc, exp[i]);
      end
    end
  endtask

  task automatic test_prog1();
    logic [7:0] exp [3];
    logic [7:0] l;
    int cyc;
    exp = '{8'h83, 8'hC1, 8'hE0};
    press();
    n_cmp++; if (program_choosen !== 3'd1) begin n_fail++; $display("FAIL prog1_sel got %0d want 1", program_choosen); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h07) begin n_fail++; $display("FAIL prog1_start got %h want 07", leds); end
    for (int i = 0; i < 3; i++) begin
      next_frame(l, cyc);
      n_cmp++; if (l !== exp[i] || cyc != 3) begin
        n_fail++; $display("FAIL prog1_f%0d got %h/%0d want %h/3", i, l, cyc, exp[i]);
      end
    end
  endtask

  task automatic test_prog2();
    logic [7:0] exp [7];
    logic [7:0] l;
    int cyc;
    exp = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38};
    @(negedge clk);  // press lands one cycle after a natural tick, so restart is visible
    press();
    n_cmp++; if (program_choosen !== 3'd2) begin n_fail++; $display("FAIL prog2_sel got %0d want 2", program_choosen); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h07) begin n_fail++; $display("FAIL prog2_start got %h want 07", leds); end
    for (int i = 0; i < 7; i++) begin
      next_frame(l, cyc);
      n_cmp++; if (l !== exp[i] || cyc != 3) begin
        n_fail++; $display("FAIL prog2_f%0d got %h/%0d want %h/3", i, l, cyc, exp[i]);
      end
    end
  endtask

  task automatic test_prog3();
    logic [7:0] exp [16];
    logic [7:0] l;
    int cyc;
    exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
            8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    press();
    n_cmp++; if (program_choosen !== 3'd3) begin n_fail++; $display("FAIL prog3_sel got %0d want 3", program_choosen); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h00) begin n_fail++; $display("FAIL prog3_start got %h want 00", leds); end
    for (int i = 0; i < 16; i++) begin
      next_frame(l, cyc);
      n_cmp++; if (l !== exp[i]) begin n_fail++; $display("FAIL prog3_f%0d got %h want %h", i, l, exp[i]); end
    end
  endtask

  task automatic test_prog4_wrap();
    logic [7:0] exp [3];
    logic [7:0] l;
    int cyc;
    exp = '{8'hFF, 8'h00, 8'hFF};
    press();
    n_cmp++; if (program_choosen !== 3'd4) begin n_fail++; $display("FAIL prog4_sel got %0d want 4", program_choosen); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h00) begin n_fail++; $display("FAIL prog4_start got %h want 00", leds); end
    for (int i = 0; i < 3; i++) begin
      next_frame(l, cyc);
      n_cmp++; if (l !== exp[i]) begin n_fail++; $display("FAIL prog4_f%0d got %h want %h", i, l, exp[i]); end
    end
    press();
    n_cmp++; if (program_choosen !== 3'd0) begin n_fail++; $display("FAIL wrap_sel got %0d want 0", program_choosen); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h07) begin n_fail++; $display("FAIL wrap_leds got %h want 07", leds); end
  endtask

  task automatic test_hold();
    btn_program = 1'b1;
    repeat (100) @(negedge clk);
    n_cmp++; if (program_choosen !== 3'd1) begin n_fail++; $display("FAIL hold_sel got %0d want 1", program_choosen); end
    btn_program = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (program_choosen !== 3'd1) begin n_fail++; $display("FAIL hold_release got %0d want 1", program_choosen); end
  endtask

  task automatic test_coincide();
    logic [7:0] l;
    int cyc;
    next_frame(l, cyc);
    btn_program = 1'b1;  // program updates on the edge where the base counter is terminal
    repeat (3) @(negedge clk);
    btn_program = 1'b0;
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL coincide_tick got %b want 0", frame_tick); end
    n_cmp++; if (program_choosen !== 3'd2) begin n_fail++; $display("FAIL coincide_sel got %0d want 2", program_choosen); end
    count_to_tick(cyc);
    n_cmp++; if (cyc != 4) begin n_fail++; $display("FAIL coincide_restart got %0d want 4", cyc); end
  endtask

  task automatic test_pause();
    logic [7:0] l;
    int cyc;
    int ticks;
    int moved;
    next_frame(l, cyc);
    n_cmp++; if (l !== 8'h1C) begin n_fail++; $display("FAIL pause_pre got %h want 1c", l); end
    pause = 1'b1;
    ticks = 0;
    moved = 0;
    repeat (20) begin
      @(negedge clk);
      if (frame_tick !== 1'b0) ticks++;
      if (leds !== 8'h1C) moved++;
    end
    n_cmp++; if (ticks != 0) begin n_fail++; $display("FAIL pause_ticks got %0d want 0", ticks); end
    n_cmp++; if (moved != 0) begin n_fail++; $display("FAIL pause_leds got %0d changes want 0", moved); end
    pause = 1'b0;
    count_to_tick(cyc);
    n_cmp++; if (cyc != 3) begin n_fail++; $display("FAIL pause_resume got %0d want 3", cyc); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h38) begin n_fail++; $display("FAIL pause_next got %h want 38", leds); end
  endtask

  task automatic test_speed();
    int cyc;
    count_to_tick(cyc);
    speed = 3'd2;
    count_to_tick(cyc);
    n_cmp++; if (cyc != 12) begin n_fail++; $display("FAIL speed2_a got %0d want 12", cyc); end
    count_to_tick(cyc);
    n_cmp++; if (cyc != 12) begin n_fail++; $display("FAIL speed2_b got %0d want 12", cyc); end
    repeat (5) @(negedge clk);
    speed = 3'd0;
    count_to_tick(cyc);
    n_cmp++; if (cyc != 3) begin n_fail++; $display("FAIL speed_drop got %0d want 3", cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    speed = 3'd1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (leds !== 8'h07) begin n_fail++; $display("FAIL rstmid_leds got %h want 07", leds); end
    n_cmp++; if (program_choosen !== 3'd0) begin n_fail++; $display("FAIL rstmid_prog got %0d want 0", program_choosen); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_tick got %b want 0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    count_to_tick(cyc);
    n_cmp++; if (cyc != 8) begin n_fail++; $display("FAIL rstmid_first got %0d want 8", cyc); end
    @(negedge clk);
    n_cmp++; if (leds !== 8'h0E) begin n_fail++; $display("FAIL rstmid_step got %h want 0e", leds); end
  endtask

  initial begin
    test_reset();
    test_prog0();
    test_prog1();
    test_prog2();
    test_prog3();
    test_prog4_wrap();
    test_hold();
    test_coincide();
    test_pause();
    test_speed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
